// File: rtl/smi_master.sv
// smi_master: initiator for the SMI parallel bus. A valid/ready command starts
// one read or write cycle. Each cycle runs through SETUP, STROBE and HOLD phases
// with parameterised lengths. All pad-facing signals come straight from flops.
module smi_master #(
   parameter int DATA_WIDTH = 8,
   parameter int SETUP      = 2,
   parameter int STROBE     = 4,
   parameter int HOLD       = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  smi_oe,
   output logic                  smi_we,
   output logic [DATA_WIDTH-1:0] smi_data_out,
   output logic                  smi_data_oe,
   input  logic [DATA_WIDTH-1:0] smi_data_in
);

   localparam int MAX_PH = (SETUP > STROBE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                            : ((STROBE > HOLD) ? STROBE : HOLD);
   localparam int CNT_W  = $clog2(MAX_PH) + 1;
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD - 1);

   // A zero-length phase would make the counter wrap; refuse to elaborate.
   if (SETUP < 1 || STROBE < 1 || HOLD < 1) begin : g_bad_timing
      $fatal(1, "smi_master: SETUP, STROBE and HOLD must all be >= 1");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    write_q, write_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic                    smi_oe_q, smi_oe_d;
   logic                    smi_we_q, smi_we_d;
   logic [DATA_WIDTH-1:0]   smi_data_out_q, smi_data_out_d;
   logic                    smi_data_oe_q, smi_data_oe_d;

   logic accept;
   logic cnt_done;
   logic capture;

   assign accept   = cmd_valid && cmd_ready_q;
   assign cnt_done = (cnt_q == '0);
   // Read data is sampled on the edge that closes the last strobe-low cycle.
   assign capture  = (state_q == ST_STROBE) && cnt_done && !write_q;

   // State register: phase, phase counter and the latched direction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
      end
   end

   // Next-state logic: the counter is reloaded on every phase entry and counts down to zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
               write_d = cmd_write;
            end
         end
         ST_SETUP: begin
            if (cnt_done) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (cnt_done) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_done) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: pin values are derived from the next state so that they register in step with it.
   always_comb begin
      cmd_ready_d    = (state_d == ST_IDLE);
      smi_data_oe_d  = (state_d != ST_IDLE) && write_d;
      smi_we_d       = !((state_d == ST_STROBE) && write_d);
      smi_oe_d       = !((state_d == ST_STROBE) && !write_d);
      smi_data_out_d = smi_data_out_q;
      if (accept && cmd_write) begin
         smi_data_out_d = cmd_data;
      end
      rsp_valid_d = capture;
      rsp_data_d  = rsp_data_q;
      if (capture) begin
         rsp_data_d = smi_data_in;
      end
   end

   // Output registers: reset releases the bus and parks both strobes high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_ready_q    <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         smi_oe_q       <= 1'b1;
         smi_we_q       <= 1'b1;
         smi_data_out_q <= '0;
         smi_data_oe_q  <= 1'b0;
      end else begin
         cmd_ready_q    <= cmd_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_data_q     <= rsp_data_d;
         smi_oe_q       <= smi_oe_d;
         smi_we_q       <= smi_we_d;
         smi_data_out_q <= smi_data_out_d;
         smi_data_oe_q  <= smi_data_oe_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign smi_oe       = smi_oe_q;
   assign smi_we       = smi_we_q;
   assign smi_data_out = smi_data_out_q;
   assign smi_data_oe  = smi_data_oe_q;

endmodule

// File: tb/tb_smi_master.sv
// tb_smi_master: directed bench for smi_master with default timing (2/4/2)
// and a second instance with minimal timing (1/1/1).
module tb_smi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;

   // default-timing instance
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       smi_oe, smi_we, smi_data_oe;
   logic [7:0] smi_data_out, smi_data_in;

   // minimal-timing instance
   logic       f_valid, f_ready, f_write;
   logic [7:0] f_data;
   logic       f_rsp_valid;
   logic [7:0] f_rsp_data;
   logic       f_oe, f_we, f_data_oe;
   logic [7:0] f_data_out, f_data_in;

   int checks = 0;
   int errors = 0;
   logic [7:0] last_wdata;
   logic [7:0] exp_rsp;

   smi_master #(.DATA_WIDTH(8), .SETUP(2), .STROBE(4), .HOLD(2)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .smi_oe(smi_oe), .smi_we(smi_we), .smi_data_out(smi_data_out),
      .smi_data_oe(smi_data_oe), .smi_data_in(smi_data_in)
   );

   smi_master #(.DATA_WIDTH(8), .SETUP(1), .STROBE(1), .HOLD(1)) dut_fast (
      .clk(clk), .reset(reset),
      .cmd_valid(f_valid), .cmd_ready(f_ready), .cmd_write(f_write), .cmd_data(f_data),
      .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data),
      .smi_oe(f_oe), .smi_we(f_we), .smi_data_out(f_data_out),
      .smi_data_oe(f_data_oe), .smi_data_in(f_data_in)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // One transaction on the default instance, starting at a negedge where
   // cmd_ready is expected high (cycle 0). Returns at the negedge of cycle 9.
   task automatic run_txn(input logic wr, input logic [7:0] d, input logic keep_valid,
                          input logic nxt_wr, input logic [7:0] nxt_d);
      logic strobe, busy;
      check_val("ready c0", {31'b0, cmd_ready}, 32'd1);
      cmd_valid   = 1'b1;
      cmd_write   = wr;
      cmd_data    = d;
      smi_data_in = 8'h00;
      if (wr) last_wdata = d;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         busy   = (c <= 8);
         strobe = (c >= 3 && c <= 6);
         check_val($sformatf("ready c%0d", c), {31'b0, cmd_ready}, {31'b0, (c == 9)});
         check_val($sformatf("oe c%0d", c), {31'b0, smi_oe}, {31'b0, !(strobe && !wr)});
         check_val($sformatf("we c%0d", c), {31'b0, smi_we}, {31'b0, !(strobe && wr)});
         check_val($sformatf("data_oe c%0d", c), {31'b0, smi_data_oe}, {31'b0, (busy && wr)});
         check_val($sformatf("data_out c%0d", c), {24'b0, smi_data_out}, {24'b0, last_wdata});
         check_val($sformatf("rsp_valid c%0d", c), {31'b0, rsp_valid}, {31'b0, (!wr && c == 7)});
         if (!wr && c >= 7)
            check_val($sformatf("rsp_data c%0d", c), {24'b0, rsp_data}, 32'h22);
         else
            check_val($sformatf("rsp_data c%0d", c), {24'b0, rsp_data}, {24'b0, exp_rsp});
         check_val($sformatf("strobe_overlap c%0d", c), {31'b0, (!smi_oe && !smi_we)}, 32'd0);
         // target data for the cycle that has just begun
         smi_data_in = (c >= 3 && c <= 5) ? 8'h11 : (c == 6) ? 8'h22 : (c >= 7) ? 8'h33 : 8'h00;
         if (keep_valid) begin
            cmd_write = (c >= 8) ? nxt_wr : c[0];
            cmd_data  = (c >= 8) ? nxt_d : 8'(c * 37);
         end else begin
            cmd_valid = 1'b0;
            cmd_write = ~wr;
            cmd_data  = ~d;
         end
      end
      if (!wr) exp_rsp = 8'h22;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_data    = 8'h00;
      smi_data_in = 8'h00;
      f_valid     = 1'b0;
      f_write     = 1'b0;
      f_data      = 8'h00;
      f_data_in   = 8'h00;
      last_wdata  = 8'h00;
      exp_rsp     = 8'h00;

      // reset held for three cycles
      repeat (3) @(negedge clk);
      check_val("rst oe", {31'b0, smi_oe}, 32'd1);
      check_val("rst we", {31'b0, smi_we}, 32'd1);
      check_val("rst data_oe", {31'b0, smi_data_oe}, 32'd0);
      check_val("rst data_out", {24'b0, smi_data_out}, 32'h00);
      check_val("rst ready", {31'b0, cmd_ready}, 32'd0);
      check_val("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check_val("rst rsp_data", {24'b0, rsp_data}, 32'h00);
      reset = 1'b1;
      #1;
      check_val("ready before edge", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
      check_val("ready after release", {31'b0, cmd_ready}, 32'd1);
      check_val("fast ready after release", {31'b0, f_ready}, 32'd1);

      // single write, then single read
      run_txn(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
      run_txn(1'b0, 8'h99, 1'b0, 1'b0, 8'h00);

      // cmd_valid held high: write 0x01, read, write 0x02
      run_txn(1'b1, 8'h01, 1'b1, 1'b0, 8'h00);
      run_txn(1'b0, 8'h00, 1'b1, 1'b1, 8'h02);
      run_txn(1'b1, 8'h02, 1'b0, 1'b0, 8'h00);

      // reset asserted in cycle 4 of a write
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_data  = 8'h3C;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_val("mid we low", {31'b0, smi_we}, 32'd0);
      check_val("mid data_oe", {31'b0, smi_data_oe}, 32'd1);
      check_val("mid data_out", {24'b0, smi_data_out}, 32'h3C);
      reset = 1'b0;
      #1;
      check_val("async we", {31'b0, smi_we}, 32'd1);
      check_val("async oe", {31'b0, smi_oe}, 32'd1);
      check_val("async data_oe", {31'b0, smi_data_oe}, 32'd0);
      check_val("async data_out", {24'b0, smi_data_out}, 32'h00);
      check_val("async ready", {31'b0, cmd_ready}, 32'd0);
      check_val("async rsp_data", {24'b0, rsp_data}, 32'h00);
      last_wdata = 8'h00;
      exp_rsp    = 8'h00;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_val($sformatf("rst hold rsp_valid %0d", i), {31'b0, rsp_valid}, 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      check_val("rsp_valid after release", {31'b0, rsp_valid}, 32'd0);
      run_txn(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

      // minimal timing: read then write with cmd_valid held, period 4
      check_val("fast ready c0", {31'b0, f_ready}, 32'd1);
      f_valid   = 1'b1;
      f_write   = 1'b0;
      f_data    = 8'h00;
      f_data_in = 8'hC3;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check_val($sformatf("fast ready c%0d", c), {31'b0, f_ready}, {31'b0, (c == 4 || c == 8)});
         check_val($sformatf("fast oe c%0d", c), {31'b0, f_oe}, {31'b0, (c != 2)});
         check_val($sformatf("fast we c%0d", c), {31'b0, f_we}, {31'b0, (c != 6)});
         check_val($sformatf("fast rsp_valid c%0d", c), {31'b0, f_rsp_valid}, {31'b0, (c == 3)});
         check_val($sformatf("fast data_oe c%0d", c), {31'b0, f_data_oe}, {31'b0, (c >= 5 && c <= 7)});
         check_val($sformatf("fast data_out c%0d", c), {24'b0, f_data_out}, (c >= 5) ? 32'h77 : 32'h00);
         check_val($sformatf("fast rsp_data c%0d", c), {24'b0, f_rsp_data}, (c >= 3) ? 32'h5A : 32'h00);
         f_data_in = (c == 2) ? 8'h5A : 8'hC3;
         if (c == 4) begin
            f_write = 1'b1;
            f_data  = 8'h77;
         end else if (c == 5) begin
            f_valid = 1'b0;
            f_write = 1'b0;
            f_data  = 8'hFF;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/smi_master.md
# smi_master

Initiator side of the SMI parallel bus: drives `smi_oe`/`smi_we` strobes and the data bus toward an SMI target, such as the FPGA-side SMI slave. It is used as a bench/bring-up master and for board-to-board links where the FPGA owns the bus. A valid/ready command port starts one read or write cycle with programmable setup/strobe/hold timing. A single-cycle response pulse returns read data. Pad tristating stays at top level; this block exports separate out/oe/in data buses.

## Interface
- `DATA_WIDTH`, 8: bus width.
- `SETUP`, 2: clock cycles data/bus state is settled before the strobe goes low (≥1).
- `STROBE`, 4: clock cycles the strobe is held low (≥1).
- `HOLD`, 2: clock cycles after the strobe rises before the cycle ends (≥1).
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block idle, command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_write`  in  1  1 = write cycle, 0 = read cycle.
- `cmd_data`  in  DATA_WIDTH  write data, ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse: read data available.
- `rsp_data`  out  DATA_WIDTH  last read data, held until the next read completes.
- `smi_oe`  out  1  read strobe, active-low.
- `smi_we`  out  1  write strobe, active-low.
- `smi_data_out`  out  DATA_WIDTH  data driven to pads.
- `smi_data_oe`  out  1  pad output enable, 1 = drive.
- `smi_data_in`  in  DATA_WIDTH  data from pads.

## Operation
- FSM states and transitions:
  - IDLE → SETUP on accept.
  - SETUP → STROBE after SETUP cycles.
  - STROBE → HOLD after STROBE cycles.
  - HOLD → IDLE after HOLD cycles.
- One down-counter is reloaded on each state entry. Its width is $clog2(max(SETUP,STROBE,HOLD))+1.
- On accept, latch `cmd_write` and `cmd_data`. Later changes on the command inputs are ignored until the next accept.
- `cmd_ready` = 1 only in IDLE.
- Write cycle:
  - `smi_data_oe` = 1 and `smi_data_out` = latched data through SETUP, STROBE and HOLD.
  - `smi_we` = 0 only in STROBE.
  - `smi_oe` stays 1.
- Read cycle:
  - `smi_data_oe` = 0 throughout.
  - `smi_oe` = 0 only in STROBE.
  - `smi_we` stays 1.
  - `smi_data_in` is registered into `rsp_data` at the edge that ends the last STROBE cycle.
  - `rsp_valid` = 1 for exactly the first HOLD cycle.
- In IDLE: `smi_oe` = 1, `smi_we` = 1, `smi_data_oe` = 0. `smi_data_out` keeps its last value.
- `smi_oe` and `smi_we` are never both 0. Data never changes while a strobe is low.
- All outputs are registered. There is no combinational path from inputs to SMI pins.
- Illegal parameters (any timing value 0) must stop simulation with an error at elaboration/initial.

## Timing
- Reset values (applied immediately while `reset` = 0):
  - `smi_oe` = 1, `smi_we` = 1, `smi_data_oe` = 0, `smi_data_out` = 0.
  - `cmd_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, state IDLE.
  - `cmd_ready` rises at the first rising edge after reset release.
- Cycle numbering: accept edge ends cycle 0.
  - SETUP occupies cycles 1..S.
  - STROBE occupies cycles S+1..S+T.
  - HOLD occupies cycles S+T+1..S+T+H.
  - `cmd_ready` = 1 again in cycle S+T+H+1.
- Throughput: one transaction per S+T+H+1 cycles. IDLE lasts at least one cycle between transactions.
- Read latency: `rsp_valid` in cycle S+T+1, the same cycle the strobe has returned high.
- Reset mid-transaction:
  - Strobes deassert and the bus is released asynchronously.
  - The command is dropped and no `rsp_valid` is issued.
  - `rsp_data` resets to 0.
- `cmd_valid` asserted while busy is not accepted and is not lost: it is accepted in the next IDLE cycle if still asserted.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles, release -> all pins at reset values; `cmd_ready` = 1 one edge after release.
- Write 0xA5 (S=2, T=4, H=2) -> `smi_data_oe` = 1 and `smi_data_out` = 0xA5 cycles 1-8; `smi_we` = 0 cycles 3-6; `smi_oe` = 1 always; `cmd_ready` = 1 at cycle 9.
- Read with target driving 0x11 in cycles 3-5, 0x22 in cycle 6, 0x33 from cycle 7 -> `smi_oe` = 0 cycles 3-6; `rsp_valid` = 1 only in cycle 7; `rsp_data` = 0x22; `smi_data_oe` = 0 throughout.
- `cmd_valid` held high for write 0x01, read, write 0x02; `cmd_data` toggled while busy -> accepts 9 cycles apart; no overlapping strobes; bus shows 0x01 then 0x02 unchanged during each cycle.
- Assert `reset` in cycle 4 of a write -> `smi_we` = 1 and `smi_data_oe` = 0 within the same cycle without a clock edge; no `rsp_valid`; after release the next read completes normally.
- Parameters S=1, T=1, H=1 -> strobe low for exactly 1 cycle; transaction period of 4 cycles; read `rsp_valid` in cycle 3.
